cdic: RTL and testbench



---
 rtl/cdic.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_cdic.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdic.sv
// cdic: CD interface controller with sector fetch, dual-buffer RAM, DMA and CD-DA.
// Define CDIC_AUDIO_EN to build the PCM playback path.
module cdic #(
  parameter int SECTOR_WORDS = 1176,
  parameter int SAMPLE_DIV   = 680
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [23:1]        address,
  input  logic [15:0]        din,
  output logic [15:0]        dout,
  input  logic               uds,
  input  logic               lds,
  input  logic               write_strobe,
  input  logic               cs,
  output logic               bus_ack,
  output logic               intreq,
  input  logic               intack,
  output logic               req,
  input  logic               ack,
  output logic               rdy,
  input  logic               dtc,
  input  logic               done_in,
  output logic               done_out,
  output logic [31:0]        cd_hps_lba,
  output logic               cd_hps_req,
  input  logic               cd_hps_ack,
  input  logic               cd_hps_data_valid,
  input  logic [15:0]        cd_hps_data,
  output logic signed [15:0] audio_left,
  output logic signed [15:0] audio_right,
  output logic               fail_not_enough_words,
  output logic               fail_too_much_data
);

  localparam int          RAM_WORDS = 7680;
  localparam int          CW        = $clog2(SECTOR_WORDS + 1);
  localparam logic [12:0] BUF1_BASE = 13'd1280;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_XFER
  } fstate_e;

  function automatic logic [15:0] bmerge(
    input logic [15:0] old_v,
    input logic [15:0] new_v,
    input logic        hi,
    input logic        lo
  );
    return {hi ? new_v[15:8] : old_v[15:8],
            lo ? new_v[7:0]  : old_v[7:0]};
  endfunction

  logic        unused_ok;
  assign unused_ok = ^address[23:14] ^ (SAMPLE_DIV > 0);

  // Bus access decode
  logic [12:0] wa;
  logic        acc_q;
  logic        bus_ack_q;
  logic        strobe;
  logic        wr;
  logic        rd;
  assign wa     = address[13:1];
  assign strobe = cs & ~acc_q;
  assign wr     = strobe & write_strobe;
  assign rd     = strobe & ~write_strobe;

  logic s_ram, s_thi, s_tlo, s_dadr, s_abuf;
  logic s_xbuf, s_dctl, s_actl, s_ivec, s_dbuf;
  assign s_ram  = wa < 13'h1E00;
  assign s_thi  = wa == 13'h1E00;
  assign s_tlo  = wa == 13'h1E01;
  assign s_dadr = wa == 13'h1FF8;
  assign s_abuf = wa == 13'h1FFA;
  assign s_xbuf = wa == 13'h1FFB;
  assign s_dctl = wa == 13'h1FFC;
  assign s_actl = wa == 13'h1FFD;
  assign s_ivec = wa == 13'h1FFE;
  assign s_dbuf = wa == 13'h1FFF;

  // Control and status registers
  logic [31:0] time_q, time_d;
  logic [12:0] dmaadr_q, dmaadr_d;
  logic [7:0]  ivec_q, ivec_d;
  logic        dbuf_q, dbuf_d;
  logic        abuf_sel_q, abuf_sel_d;
  logic        abuf_done_q, abuf_done_d;
  logic        xbuf_rdy_q, xbuf_rdy_d;
  logic        xbuf_buf_q, xbuf_buf_d;
  logic        dma_act_q, dma_act_d;
  logic        dma_dir_q, dma_dir_d;
  logic        done_out_q, done_out_d;
  logic        rdy_q;
  logic        rsel_ram_q;
  logic [15:0] rreg_q;
  logic [15:0] rreg;

  // Fetch FSM
  fstate_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        fbuf_q, fbuf_d;
  logic [31:0] lba_q, lba_d;
  logic        fne_q, fne_d;
  logic        ftm_q, ftm_d;
  logic        hps_we;
  logic        fetch_done;
  logic [12:0] hps_wa;

  logic        aud_play;
  logic        aud_done;

  // RAM ports
  logic [15:0] ram [RAM_WORDS];
  logic        ram_we;
  logic [12:0] ram_wa;
  logic [15:0] ram_wd;
  logic [1:0]  ram_be;
  logic [12:0] cpu_ra;
  logic [12:0] dma_ra;
  logic [15:0] cpu_rd_q;
  logic [15:0] dma_rd_q;
  logic        dma_we;

  assign hps_wa = (fbuf_q ? BUF1_BASE : 13'd0) + 13'(cnt_q);
  assign dma_we = ack & dma_dir_q & dtc;
  assign cpu_ra = s_ram ? wa : 13'd0;
  assign dma_ra = (dmaadr_q < 13'(RAM_WORDS)) ? dmaadr_q : 13'd0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fbuf_d     = fbuf_q;
    lba_d      = lba_q;
    fne_d      = fne_q;
    ftm_d      = ftm_q;
    hps_we     = 1'b0;
    fetch_done = 1'b0;
    unique case (state_q)
      F_IDLE: begin
        if (wr && s_dbuf && uds && din[15]) begin
          state_d = F_REQ;
          fbuf_d  = lds ? din[0] : dbuf_q;
          lba_d   = time_q;
        end
      end
      F_REQ: begin
        if (cd_hps_ack) begin
          state_d = F_XFER;
          cnt_d   = '0;
        end
      end
      F_XFER: begin
        if (cd_hps_data_valid) begin
          if (cnt_q < CW'(SECTOR_WORDS)) begin
            hps_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end else begin
            ftm_d = 1'b1;
          end
        end
        if (!cd_hps_ack) begin
          if (cnt_d < CW'(SECTOR_WORDS)) fne_d = 1'b1;
          fetch_done = 1'b1;
          state_d    = F_IDLE;
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

  always_comb begin
    time_d      = time_q;
    dmaadr_d    = dmaadr_q;
    ivec_d      = ivec_q;
    dbuf_d      = dbuf_q;
    abuf_sel_d  = abuf_sel_q;
    abuf_done_d = abuf_done_q;
    xbuf_rdy_d  = xbuf_rdy_q;
    xbuf_buf_d  = xbuf_buf_q;
    dma_act_d   = dma_act_q;
    dma_dir_d   = dma_dir_q;
    done_out_d  = 1'b0;
    if (wr) begin
      unique case (1'b1)
        s_thi: time_d[31:16] = bmerge(time_q[31:16], din, uds, lds);
        s_tlo: time_d[15:0]  = bmerge(time_q[15:0], din, uds, lds);
        s_dadr: begin
          if (uds) dmaadr_d[12:8] = din[12:8];
          if (lds) dmaadr_d[7:0]  = din[7:0];
        end
        s_abuf: if (lds) abuf_sel_d = din[0];
        s_dctl: begin
          if (uds) begin
            dma_act_d  = din[15];
            dma_dir_d  = din[14];
            done_out_d = dma_act_q & ~din[15];
          end
        end
        s_ivec: if (lds) ivec_d = din[7:0];
        s_dbuf: if (lds) dbuf_d = din[0];
        default: ;
      endcase
    end
    if (dtc && ack) dmaadr_d = dmaadr_d + 13'd1;
    if (done_in) dma_act_d = 1'b0;
    // Status clear on read loses against a same-cycle set
    if (rd && s_xbuf) xbuf_rdy_d = 1'b0;
    if (rd && s_abuf) abuf_done_d = 1'b0;
    if (fetch_done) begin
      xbuf_rdy_d = 1'b1;
      xbuf_buf_d = fbuf_q;
    end
    if (aud_done) abuf_done_d = 1'b1;
  end

  always_comb begin
    rreg = 16'h0000;
    unique case (1'b1)
      s_thi:  rreg = time_q[31:16];
      s_tlo:  rreg = time_q[15:0];
      s_dadr: rreg = {3'b000, dmaadr_q};
      s_abuf: rreg = {abuf_done_q, 14'b0, abuf_sel_q};
      s_xbuf: rreg = {xbuf_rdy_q, 14'b0, xbuf_buf_q};
      s_dctl: rreg = {dma_act_q, dma_dir_q, 14'b0};
      s_actl: rreg = {aud_play, 15'b0};
      s_ivec: rreg = {8'h00, ivec_q};
      s_dbuf: rreg = {state_q != F_IDLE, 14'b0, dbuf_q};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= 1'b0;
      bus_ack_q   <= 1'b0;
      rsel_ram_q  <= 1'b0;
      rreg_q      <= '0;
      time_q      <= '0;
      dmaadr_q    <= '0;
      ivec_q      <= 8'h0F;
      dbuf_q      <= 1'b0;
      abuf_sel_q  <= 1'b0;
      abuf_done_q <= 1'b0;
      xbuf_rdy_q  <= 1'b0;
      xbuf_buf_q  <= 1'b0;
      dma_act_q   <= 1'b0;
      dma_dir_q   <= 1'b0;
      done_out_q  <= 1'b0;
      rdy_q       <= 1'b0;
      state_q     <= F_IDLE;
      cnt_q       <= '0;
      fbuf_q      <= 1'b0;
      lba_q       <= '0;
      fne_q       <= 1'b0;
      ftm_q       <= 1'b0;
    end else begin
      acc_q       <= cs;
      bus_ack_q   <= strobe;
      if (strobe) begin
        rsel_ram_q <= s_ram;
        rreg_q     <= rreg;
      end
      time_q      <= time_d;
      dmaadr_q    <= dmaadr_d;
      ivec_q      <= ivec_d;
      dbuf_q      <= dbuf_d;
      abuf_sel_q  <= abuf_sel_d;
      abuf_done_q <= abuf_done_d;
      xbuf_rdy_q  <= xbuf_rdy_d;
      xbuf_buf_q  <= xbuf_buf_d;
      dma_act_q   <= dma_act_d;
      dma_dir_q   <= dma_dir_d;
      done_out_q  <= done_out_d;
      // The word after a dtc is still being read, so hold rdy off for it
      rdy_q       <= ack & ~dtc;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fbuf_q      <= fbuf_d;
      lba_q       <= lba_d;
      fne_q       <= fne_d;
      ftm_q       <= ftm_d;
    end
  end

  always_comb begin
    ram_we = 1'b0;
    ram_wa = '0;
    ram_wd = '0;
    ram_be = 2'b00;
    if (hps_we) begin
      ram_we = 1'b1;
      ram_wa = hps_wa;
      ram_wd = cd_hps_data;
      ram_be = 2'b11;
    end else if (dma_we) begin
      ram_we = 1'b1;
      ram_wa = dmaadr_q;
      ram_wd = din;
      ram_be = 2'b11;
    end else if (wr && s_ram) begin
      ram_we = 1'b1;
      ram_wa = wa;
      ram_wd = din;
      ram_be = {uds, lds};
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we && ram_wa < 13'(RAM_WORDS)) begin
      if (ram_be[1]) ram[ram_wa][15:8] <= ram_wd[15:8];
      if (ram_be[0]) ram[ram_wa][7:0]  <= ram_wd[7:0];
    end
    cpu_rd_q <= ram[cpu_ra];
    dma_rd_q <= ram[dma_ra];
  end

`ifdef CDIC_AUDIO_EN
  localparam int DW = $clog2(SAMPLE_DIV);

  logic          play_q, play_d;
  logic [DW-1:0] div_q, div_d;
  logic [9:0]    pair_q, pair_d;
  logic [15:0]   lpend_q, lpend_d;
  logic [15:0]   left_q, left_d;
  logic [15:0]   right_q, right_d;
  logic [12:0]   aud_ra;
  logic [15:0]   aud_rd_q;

  // L is fetched at div 0, R at div 1; both land together at div 2
  assign aud_ra = (abuf_sel_q ? BUF1_BASE : 13'd0)
                + {2'b00, pair_q, div_q == DW'(1)};

  always_ff @(posedge clk) begin
    aud_rd_q <= ram[aud_ra];
  end

  always_comb begin
    play_d   = play_q;
    div_d    = div_q;
    pair_d   = pair_q;
    lpend_d  = lpend_q;
    left_d   = left_q;
    right_d  = right_q;
    aud_done = 1'b0;
    if (play_q) begin
      div_d = (div_q == DW'(SAMPLE_DIV - 1)) ? '0 : div_q + 1'b1;
      if (div_q == DW'(1)) lpend_d = aud_rd_q;
      if (div_q == DW'(2)) begin
        left_d  = lpend_q;
        right_d = aud_rd_q;
        if (pair_q == 10'd587) begin
          play_d   = 1'b0;
          aud_done = 1'b1;
        end else begin
          pair_d = pair_q + 10'd1;
        end
      end
    end
    if (wr && s_actl && uds) begin
      play_d = din[15];
      div_d  = '0;
      pair_d = '0;
      if (!din[15]) begin
        left_d  = '0;
        right_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      play_q  <= 1'b0;
      div_q   <= '0;
      pair_q  <= '0;
      lpend_q <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      play_q  <= play_d;
      div_q   <= div_d;
      pair_q  <= pair_d;
      lpend_q <= lpend_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign aud_play    = play_q;
  assign audio_left  = left_q;
  assign audio_right = right_q;
`else
  assign aud_play    = 1'b0;
  assign aud_done    = 1'b0;
  assign audio_left  = '0;
  assign audio_right = '0;
`endif

  always_comb begin
    dout = 16'h0000;
    if (intack) begin
      dout = {8'h00, ivec_q};
    end else if (bus_ack_q) begin
      dout = rsel_ram_q ? cpu_rd_q : rreg_q;
    end else if (ack && !dma_dir_q) begin
      dout = dma_rd_q;
    end
  end

  assign bus_ack               = bus_ack_q;
  assign intreq                = xbuf_rdy_q | abuf_done_q;
  assign req                   = dma_act_q;
  assign rdy                   = dma_dir_q ? ack : (rdy_q & ack);
  assign done_out              = done_out_q;
  assign cd_hps_lba            = lba_q;
  assign cd_hps_req            = state_q == F_REQ;
  assign fail_not_enough_words = fne_q;
  assign fail_too_much_data    = ftm_q;

endmodule

// File: tb/tb_cdic.sv
// tb_cdic: directed self-checking bench for the cdic controller.
// Audio checks depend on whether CDIC_AUDIO_EN is defined.
`timescale 1ns/1ps
module tb_cdic;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:1] address;
  logic [15:0] din;
  logic [15:0] dout;
  logic        uds, lds, write_strobe, cs;
  logic        bus_ack, intreq, intack;
  logic        req, ack, rdy, dtc, done_in, done_out;
  logic [31:0] cd_hps_lba;
  logic        cd_hps_req, cd_hps_ack, cd_hps_data_valid;
  logic [15:0] cd_hps_data;
  logic signed [15:0] audio_left, audio_right;
  logic        fail_not_enough_words, fail_too_much_data;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [15:0] rd_val;
  int          ack_cyc;
  logic        ack_extra;

  always #5 clk = ~clk;

  always @(negedge clk) if (done_out) done_cnt++;

  cdic dut (
    .clk(clk), .reset_n(reset_n), .address(address), .din(din),
    .dout(dout), .uds(uds), .lds(lds), .write_strobe(write_strobe),
    .cs(cs), .bus_ack(bus_ack), .intreq(intreq), .intack(intack),
    .req(req), .ack(ack), .rdy(rdy), .dtc(dtc), .done_in(done_in),
    .done_out(done_out), .cd_hps_lba(cd_hps_lba),
    .cd_hps_req(cd_hps_req), .cd_hps_ack(cd_hps_ack),
    .cd_hps_data_valid(cd_hps_data_valid), .cd_hps_data(cd_hps_data),
    .audio_left(audio_left), .audio_right(audio_right),
    .fail_not_enough_words(fail_not_enough_words),
    .fail_too_much_data(fail_too_much_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [13:0] boff, input logic w,
                     input logic [15:0] d, input logic u, input logic l);
    @(negedge clk);
    address = 23'h180000 | 23'(boff >> 1);
    din = d; write_strobe = w; uds = u; lds = l; cs = 1'b1;
    ack_cyc = 0;
    for (int i = 1; i <= 8 && ack_cyc == 0; i++) begin
      @(posedge clk); #1;
      if (bus_ack) begin
        ack_cyc = i;
        rd_val  = dout;
      end
    end
    @(posedge clk); #1;
    ack_extra = bus_ack;
    @(negedge clk);
    cs = 1'b0; write_strobe = 1'b0; uds = 1'b0; lds = 1'b0;
    if (ack_cyc == 0) chk("bus_ack_timeout", 32'(ack_cyc), 1);
  endtask

  task automatic wr16(input logic [13:0] boff, input logic [15:0] d);
    bus(boff, 1'b1, d, 1'b1, 1'b1);
  endtask

  task automatic rd16(input logic [13:0] boff);
    bus(boff, 1'b0, 16'h0000, 1'b1, 1'b1);
  endtask

  task automatic fetch(input int n, input logic [15:0] seed);
    int t;
    t = 0;
    while (!cd_hps_req && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cd_hps_req) chk("hps_req_timeout", 32'(cd_hps_req), 1);
    @(negedge clk);
    cd_hps_ack = 1'b1;
    @(negedge clk);
    chk("hps_req_drop", 32'(cd_hps_req), 0);
    for (int i = 0; i < n; i++) begin
      cd_hps_data = seed + 16'(i);
      cd_hps_data_valid = 1'b1;
      @(negedge clk);
    end
    cd_hps_data_valid = 1'b0;
    cd_hps_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic dtc_pulse();
    @(negedge clk);
    dtc = 1'b1;
    @(negedge clk);
    dtc = 1'b0;
  endtask

  task automatic dma_done();
    @(negedge clk);
    ack = 1'b0; done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    address = '0; din = '0; uds = 0; lds = 0; write_strobe = 0; cs = 0;
    intack = 0; ack = 0; dtc = 0; done_in = 0;
    cd_hps_ack = 0; cd_hps_data_valid = 0; cd_hps_data = '0;
    #22;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_hps_req", 32'(cd_hps_req), 0);
    chk("rst_intreq", 32'(intreq), 0);
    chk("rst_bus_ack", 32'(bus_ack), 0);
    chk("rst_fails", {30'd0, fail_not_enough_words, fail_too_much_data}, 0);
    chk("rst_audio", {audio_left, audio_right}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rd16(14'h3FFC);
    chk("rst_ivec", 32'(rd_val), 32'h000F);
    rd16(14'h3FF6);
    chk("rst_xbuf", 32'(rd_val), 0);

    // Full sector into buffer 1
    wr16(14'h3C00, 16'h0000);
    wr16(14'h3C02, 16'h1234);
    rd16(14'h3C02);
    chk("time_lo_rd", 32'(rd_val), 32'h1234);
    wr16(14'h3FFE, 16'h8001);
    chk("hps_req", 32'(cd_hps_req), 1);
    chk("hps_lba", cd_hps_lba, 32'h0000_1234);
    fetch(1176, 16'h1000);
    chk("fetch_intreq", 32'(intreq), 1);
    chk("fetch_fails", {30'd0, fail_not_enough_words, fail_too_much_data}, 0);
    rd16(14'h3FF6);
    chk("xbuf_rd", 32'(rd_val), 32'h8001);
    chk("xbuf_clr_int", 32'(intreq), 0);
    rd16(14'h0A00);
    chk("buf1_first", 32'(rd_val), 32'h1000);
    rd16(14'h132E);
    chk("buf1_last", 32'(rd_val), 32'h1497);

    // Short sector, then long sector into buffer 0
    wr16(14'h3FFE, 16'h8000);
    fetch(1000, 16'h2000);
    chk("short_fne", 32'(fail_not_enough_words), 1);
    chk("short_ftm", 32'(fail_too_much_data), 0);
    rd16(14'h3FF6);
    chk("short_xbuf", 32'(rd_val), 32'h8000);
    wr16(14'h0930, 16'hBEEF);
    wr16(14'h3FFE, 16'h8000);
    fetch(1180, 16'h3000);
    chk("long_ftm", 32'(fail_too_much_data), 1);
    chk("fne_sticky", 32'(fail_not_enough_words), 1);
    rd16(14'h0930);
    chk("word1176_kept", 32'(rd_val), 32'hBEEF);
    rd16(14'h092E);
    chk("word1175", 32'(rd_val), 32'h3497);

    // Vector on intack
    wr16(14'h3FFC, 16'h005A);
    chk("int_pending", 32'(intreq), 1);
    @(negedge clk);
    intack = 1'b1;
    #1;
    chk("ivec_dout", 32'(dout), 32'h005A);
    @(negedge clk);
    intack = 1'b0;
    rd16(14'h3FF6);
    chk("xbuf_buf0", 32'(rd_val), 32'h8000);
    chk("int_cleared", 32'(intreq), 0);

    // DMA CDIC to memory
    wr16(14'h3FF0, 16'h0000);
    wr16(14'h3FF8, 16'h8000);
    chk("dma_req", 32'(req), 1);
    @(negedge clk);
    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!rdy && n < 10);
      chk("dma_rdy", 32'(rdy), 1);
      chk("dma_word", 32'(dout), 32'h3000 + 32'(i));
      dtc_pulse();
    end
    dma_done();
    chk("dma_done_req", 32'(req), 0);
    rd16(14'h3FF0);
    chk("dmaadr_4", 32'(rd_val), 4);
    rd16(14'h3FF8);
    chk("dmactl_clr", 32'(rd_val), 0);

    // Host abort
    wr16(14'h3FF8, 16'h8000);
    chk("abort_req_on", 32'(req), 1);
    chk("no_done_out", 32'(done_cnt), 0);
    wr16(14'h3FF8, 16'h0000);
    chk("abort_req_off", 32'(req), 0);
    chk("done_out_pulse", 32'(done_cnt), 1);

    // DMA memory to CDIC
    wr16(14'h3FF0, 16'h000A);
    wr16(14'h3FF8, 16'hC000);
    @(negedge clk);
    ack = 1'b1; din = 16'h7E57;
    #1;
    chk("dma_w_rdy", 32'(rdy), 1);
    dtc_pulse();
    dma_done();
    rd16(14'h0014);
    chk("dma_w_data", 32'(rd_val), 32'h7E57);
    rd16(14'h3FF0);
    chk("dmaadr_11", 32'(rd_val), 11);

    // DMAADR wraps
    wr16(14'h3FF0, 16'h1FFF);
    wr16(14'h3FF8, 16'h8000);
    @(negedge clk);
    ack = 1'b1;
    dtc_pulse();
    dma_done();
    rd16(14'h3FF0);
    chk("dmaadr_wrap", 32'(rd_val), 0);

    // Byte lanes and bus_ack timing
    wr16(14'h000A, 16'h0000);
    bus(14'h000A, 1'b1, 16'hFFAB, 1'b0, 1'b1);
    chk("ack_cycle2", 32'(ack_cyc), 1);
    chk("ack_single", 32'(ack_extra), 0);
    rd16(14'h000A);
    chk("lds_write", 32'(rd_val), 32'h00AB);
    bus(14'h000A, 1'b1, 16'h77FF, 1'b1, 1'b0);
    rd16(14'h000A);
    chk("uds_write", 32'(rd_val), 32'h77AB);

    // Unmapped space
    wr16(14'h3D00, 16'hFFFF);
    rd16(14'h3D00);
    chk("unmapped_a", 32'(rd_val), 0);
    rd16(14'h3C04);
    chk("unmapped_b", 32'(rd_val), 0);

`ifdef CDIC_AUDIO_EN
    wr16(14'h3FF4, 16'h0000);
    wr16(14'h3FFA, 16'h8000);
    n = 0;
    while (audio_left !== 16'sh3000 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("aud_l0", 32'(audio_left), 32'h3000);
    chk("aud_r0", 32'(audio_right), 32'h3001);
    n = 0;
    while (audio_left === 16'sh3000 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("aud_period", 32'(n), 680);
    chk("aud_l1", 32'(audio_left), 32'h3002);
    chk("aud_r1", 32'(audio_right), 32'h3003);
    rd16(14'h3FFA);
    chk("audctl_play", 32'(rd_val), 32'h8000);
    wr16(14'h3FFA, 16'h0000);
    chk("aud_stop", {audio_left, audio_right}, 0);
`else
    wr16(14'h3FFA, 16'h8000);
    rd16(14'h3FFA);
    chk("audctl_off", 32'(rd_val), 0);
    repeat (700) @(posedge clk);
    #1;
    chk("audio_off", {audio_left, audio_right}, 0);
    rd16(14'h3FF4);
    chk("abuf_off", 32'(rd_val), 0);
`endif

    // Asynchronous reset mid-operation
    wr16(14'h3FFE, 16'h8001);
    wr16(14'h3FF8, 16'h8000);
    chk("pre_rst_hps", 32'(cd_hps_req), 1);
    chk("pre_rst_req", 32'(req), 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_hps", 32'(cd_hps_req), 0);
    chk("arst_req", 32'(req), 0);
    chk("arst_fails", {30'd0, fail_not_enough_words, fail_too_much_data}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rd16(14'h3FFC);
    chk("arst_ivec", 32'(rd_val), 32'h000F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
